// File: rtl/imem_debug_ctrl_pkg.sv
// Shared constants for the instruction-memory debug/loader controller.
package imem_debug_ctrl_pkg;

  localparam int unsigned NB_CMD = 8;

  // Controller states; the encoding is visible on o_state for debug.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RUN        = 3'd2,
    ST_STEP_WAIT  = 3'd3,
    ST_STEP_PULSE = 3'd4,
    ST_ACK        = 3'd5
  } state_e;

  // Host command bytes.
  localparam logic [NB_CMD-1:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [NB_CMD-1:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [NB_CMD-1:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [NB_CMD-1:0] CMD_NEXT = 8'h4E;  // 'N'
  localparam logic [NB_CMD-1:0] CMD_EXIT = 8'h45;  // 'E'

  // Status byte sent when the pipeline halts.
  localparam logic [NB_CMD-1:0] RSP_HALT = 8'h48;  // 'H'

  // Instruction that terminates a program load.
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_debug_ctrl_word_assembler.sv
// Shifts received bytes MSB-first into an instruction word and flags the
// cycle in which the last byte of a word arrives.
module dbg_word_assembler #(
  parameter int unsigned NB_INST = 32,
  parameter int unsigned NB_DATA = 8
) (
  input  logic               i_clk,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_byte,
  output logic               o_word_valid_c,
  output logic [NB_INST-1:0] o_word_c
);

  localparam int unsigned N_BYTES = NB_INST / NB_DATA;
  localparam int unsigned NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int unsigned NB_HIST = NB_INST - NB_DATA;

  logic [NB_HIST-1:0] r_shift;
  logic [NB_CNT-1:0]  r_count;
  logic               w_last;

  assign w_last         = (r_count == NB_CNT'(N_BYTES - 1));
  assign o_word_c       = {r_shift, i_byte};
  assign o_word_valid_c = i_valid && w_last;

  // Byte history and position within the current word.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_valid) begin
      r_shift <= o_word_c[NB_HIST-1:0];
      r_count <= w_last ? '0 : r_count + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/imem_debug_ctrl.sv
// Debug/loader controller: loads instruction memory from a UART byte
// stream, then runs or single-steps the pipeline and reports status bytes.
module imem_debug_ctrl
  import imem_debug_ctrl_pkg::*;
#(
  parameter int unsigned        NB_ADDR   = 32,
  parameter int unsigned        NB_INST   = 32,
  parameter int unsigned        NB_DATA   = 8,
  parameter int unsigned        N_WORDS   = 256,
  parameter logic [NB_INST-1:0] HALT_WORD = NB_INST'(HALT_WORD_DEFAULT)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_done,
  input  logic               i_halt,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_write,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_enable,
  output logic               o_pipe_reset,
  output logic [2:0]         o_state
);

  // One spare bit so a full memory count (N_WORDS) is representable.
  localparam int unsigned NB_WCNT = $clog2(N_WORDS) + 1;

  state_e             r_state;
  state_e             w_state_next;
  logic [NB_WCNT-1:0] r_word_count;
  logic [NB_WCNT-1:0] w_word_count_next;
  logic [NB_WCNT-1:0] w_word_count_inc;

  logic               r_write;
  logic               w_write_next;
  logic [NB_INST-1:0] r_instruction;
  logic [NB_INST-1:0] w_instruction_next;
  logic [NB_ADDR-1:0] r_address;
  logic [NB_ADDR-1:0] w_address_next;
  logic               r_enable;
  logic               w_enable_next;
  logic               r_pipe_reset;
  logic               w_pipe_reset_next;
  logic               r_tx_start;
  logic               w_tx_start_next;
  logic [NB_DATA-1:0] r_tx_data;
  logic [NB_DATA-1:0] w_tx_data_next;

  logic               w_load_start;
  logic               w_asm_clear;
  logic               w_asm_valid;
  logic               w_word_valid;
  logic [NB_INST-1:0] w_word;

  assign w_load_start     = (r_state == ST_IDLE) && i_rx_valid &&
                            (i_rx_data == NB_DATA'(CMD_LOAD));
  assign w_asm_clear      = i_reset || w_load_start;
  assign w_asm_valid      = (r_state == ST_LOAD) && i_rx_valid;
  assign w_word_count_inc = r_word_count + NB_WCNT'(1);

  dbg_word_assembler #(
    .NB_INST (NB_INST),
    .NB_DATA (NB_DATA)
  ) u_word_assembler (
    .i_clk          (i_clk),
    .i_clear        (w_asm_clear),
    .i_valid        (w_asm_valid),
    .i_byte         (i_rx_data),
    .o_word_valid_c (w_word_valid),
    .o_word_c       (w_word)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, word counter and next values of the registered outputs.
  always_comb begin
    w_state_next       = r_state;
    w_word_count_next  = r_word_count;
    w_write_next       = 1'b0;
    w_instruction_next = r_instruction;
    w_address_next     = r_address;
    w_enable_next      = 1'b0;
    w_pipe_reset_next  = 1'b0;
    w_tx_start_next    = 1'b0;
    w_tx_data_next     = r_tx_data;

    case (r_state)
      ST_IDLE: begin
        if (w_load_start) begin
          w_state_next      = ST_LOAD;
          w_word_count_next = '0;
        end else if (i_rx_valid && (i_rx_data == NB_DATA'(CMD_CONT))) begin
          w_state_next      = ST_RUN;
          w_pipe_reset_next = 1'b1;
        end else if (i_rx_valid && (i_rx_data == NB_DATA'(CMD_STEP))) begin
          w_state_next      = ST_STEP_WAIT;
          w_pipe_reset_next = 1'b1;
        end
      end

      ST_LOAD: begin
        if (w_word_valid) begin
          w_write_next       = 1'b1;
          w_instruction_next = w_word;
          w_address_next     = NB_ADDR'({r_word_count, 2'b00});
          w_word_count_next  = w_word_count_inc;
          // The halt word is still written; the memory-full check
          // fires before the counter could exceed its range.
          if ((w_word == HALT_WORD) ||
              (w_word_count_inc == NB_WCNT'(N_WORDS))) begin
            w_state_next    = ST_ACK;
            w_tx_start_next = 1'b1;
            w_tx_data_next  = NB_DATA'(w_word_count_inc);
          end
        end
      end

      ST_RUN: begin
        if (i_halt) begin
          w_state_next    = ST_ACK;
          w_tx_start_next = 1'b1;
          w_tx_data_next  = NB_DATA'(RSP_HALT);
        end else begin
          w_enable_next = 1'b1;
        end
      end

      ST_STEP_WAIT: begin
        // A halt outranks a command byte arriving in the same cycle.
        if (i_halt) begin
          w_state_next    = ST_ACK;
          w_tx_start_next = 1'b1;
          w_tx_data_next  = NB_DATA'(RSP_HALT);
        end else if (i_rx_valid && (i_rx_data == NB_DATA'(CMD_NEXT))) begin
          w_state_next  = ST_STEP_PULSE;
          w_enable_next = 1'b1;
        end else if (i_rx_valid && (i_rx_data == NB_DATA'(CMD_EXIT))) begin
          w_state_next = ST_IDLE;
        end
      end

      ST_STEP_PULSE: begin
        w_state_next = ST_STEP_WAIT;
      end

      ST_ACK: begin
        if (i_tx_done) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Word counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word_count  <= '0;
      r_write       <= 1'b0;
      r_instruction <= '0;
      r_address     <= '0;
      r_enable      <= 1'b0;
      r_pipe_reset  <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
    end else begin
      r_word_count  <= w_word_count_next;
      r_write       <= w_write_next;
      r_instruction <= w_instruction_next;
      r_address     <= w_address_next;
      r_enable      <= w_enable_next;
      r_pipe_reset  <= w_pipe_reset_next;
      r_tx_start    <= w_tx_start_next;
      r_tx_data     <= w_tx_data_next;
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_write       = r_write;
  assign o_instruction = r_instruction;
  assign o_address     = r_address;
  assign o_enable      = r_enable;
  assign o_pipe_reset  = r_pipe_reset;
  assign o_state       = r_state;

endmodule

// File: doc/imem_debug_ctrl.md
Name: imem_debug_ctrl

Overview:
- Debug/loader controller for the instruction-fetch stage.
- Consumes a byte stream from the UART receiver, assembles 32-bit instructions and writes them sequentially into instruction memory through the fetch stage's write port.
- After loading, sequences execution by driving the pipeline enable in continuous or single-step mode, stops on the pipeline's halt indication, and reports status bytes to the UART transmitter.

Parameters:
- NB_ADDR, 32, instruction-memory byte-address width
- NB_INST, 32, instruction width
- NB_DATA, 8, UART byte width
- N_WORDS, 256, instruction-memory depth in words; load terminates after this many words
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that ends a load

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_tx_done  in  1  one-cycle strobe, transmitter finished current byte
- i_halt  in  1  pipeline retired HALT; level, sampled each cycle
- o_tx_data  out  NB_DATA  byte to transmit; stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle transmit request
- o_write  out  1  one-cycle instruction-memory write strobe
- o_instruction  out  NB_INST  write data
- o_address  out  NB_ADDR  write byte address
- o_enable  out  1  pipeline/fetch enable
- o_pipe_reset  out  1  one-cycle pipeline reset pulse (PC to 0)
- o_state  out  3  current state encoding, for debug

Behaviour:
- Reset: all outputs 0. State IDLE. Byte counter, word counter and assembly register cleared. Reset mid-load discards any partial word; memory contents are not touched. Reset mid-run drops o_enable in the same clock edge.
- Commands are accepted only in IDLE. Unknown bytes are ignored.
  - 'L' (0x4C) -> LOAD
  - 'C' (0x43) -> RUN
  - 'S' (0x53) -> STEP_WAIT
- LOAD:
  - Bytes arrive MSB first and are shifted into the assembly register.
  - On the 4th byte's i_rx_valid, the next cycle has: o_write=1 for one cycle, o_instruction = assembled word, o_address = word_count*4.
  - word_count then increments and the byte counter returns to 0.
  - Load ends after the write of HALT_WORD (which is itself written) or after the N_WORDS-th write, whichever comes first.
  - On load end, go to ACK with o_tx_data = word_count[7:0]. A count of N_WORDS=256 reports 0x00.
- Entry from IDLE to RUN or STEP_WAIT: o_pipe_reset=1 for exactly the cycle after the command byte; o_enable=0 that cycle.
- RUN:
  - o_enable=1 from the following cycle onward.
  - When i_halt is sampled high, o_enable=0 from the next cycle; go to ACK with o_tx_data=0x48 ('H').
  - Received bytes are ignored.
- STEP_WAIT (o_enable=0):
  - 'N' (0x4E) -> STEP_PULSE.
  - 'E' (0x45) -> IDLE.
  - i_halt high -> ACK with 'H'. If i_halt and i_rx_valid coincide, halt wins.
- STEP_PULSE: o_enable=1 for exactly one cycle, then STEP_WAIT.
- ACK:
  - o_tx_start=1 on the entry cycle only; o_tx_data held.
  - Wait for i_tx_done, then IDLE.
  - Received bytes are ignored.
  - An i_tx_done arriving while not in ACK is ignored.
- Arithmetic: word_count is clog2(N_WORDS)+1 bits. The address is zero-extended word_count shifted left 2. No wrap: termination precedes overflow.
- State encoding: IDLE=0, LOAD=1, RUN=2, STEP_WAIT=3, STEP_PULSE=4, ACK=5.

Decomposition:
- Shared package holds:
  - state encodings
  - command byte constants CMD_LOAD, CMD_CONT, CMD_STEP, CMD_NEXT, CMD_EXIT
  - status byte RSP_HALT
  - HALT_WORD default
- One sub-module: dbg_word_assembler.
  - Byte shift register plus 2-bit byte counter.
  - Outputs a one-cycle word_valid and the word.
  - Clear input driven on reset and on LOAD entry.
- The FSM, counters and TX handshake stay in the top module.

Test Plan:
- Load: 'L', then bytes 12 34 56 78, AB CD EF 01, FF FF FF FF -> three o_write pulses: (0x0, 0x12345678), (0x4, 0xABCDEF01), (0x8, 0xFFFFFFFF); o_tx_start with o_tx_data=0x03; i_tx_done -> IDLE.
- Memory full: N_WORDS=4, 'L' + 5 non-halt words -> exactly 4 writes at addresses 0x0–0xC; ACK 0x04; 5th word's bytes ignored in IDLE.
- Continuous: 'C' -> o_pipe_reset pulse one cycle, then o_enable=1; i_halt raised after 10 cycles -> o_enable=0 next cycle, TX 0x48, IDLE after i_tx_done.
- Step: 'S', then 'N' three times -> exactly three single-cycle o_enable pulses; 'E' -> IDLE with o_enable=0; 'N' in IDLE ignored.
- Halt/byte collision: in STEP_WAIT, 'N' strobe in the same cycle as i_halt=1 -> no enable pulse, TX 0x48.
- Reset mid-load: 'L' + 12 34, assert i_reset one cycle, then 'L' + AA BB CC DD FF FF FF FF -> first write (0x0, 0xAABBCCDD), no stale bytes; ACK 0x02.
